// File: rtl/shift_reg.sv
// Serial-in, parallel-out bidirectional shift register.
// Each enabled edge shifts d in at the LSB (left shift) or at the MSB (right shift).
// The register drives out directly, so no input reaches out without passing a flop.
module shift_reg #(
    parameter int unsigned MSB = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           d,
    input  logic           en,
    input  logic           dir,
    output logic [MSB-1:0] out
);

    logic [MSB-1:0] reg_q;
    logic [MSB-1:0] reg_d;

    // Next-state selection: hold, shift left (d into bit 0) or shift right (d into bit MSB-1)
    always_comb begin
        reg_d = reg_q;
        if (en) begin
            if (dir) begin
                reg_d = {d, reg_q[MSB-1:1]};
            end else begin
                reg_d = {reg_q[MSB-2:0], d};
            end
        end
    end

    // State register with synchronous active-low clear that overrides en and dir
    always_ff @(posedge clk) begin
        if (!rstn) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign out = reg_q;

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: a 16-bit and a 4-bit instance share stimulus.
// Expected words come from an arithmetic reference model pushed into a scoreboard
// queue when stimulus is applied and popped when the output is sampled.
module tb_shift_reg;

    typedef struct packed {
        logic [15:0] e16;
        logic [3:0]  e4;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        d;
    logic        en;
    logic        dir;
    logic [15:0] out16;
    logic [3:0]  out4;

    int checks;
    int errors;

    exp_t        sb_q[$];
    logic [15:0] m16;
    logic [3:0]  m4;

    shift_reg #(.MSB(16)) u_dut16 (
        .clk  (clk),
        .rstn (rstn),
        .d    (d),
        .en   (en),
        .dir  (dir),
        .out  (out16)
    );

    shift_reg #(.MSB(4)) u_dut4 (
        .clk  (clk),
        .rstn (rstn),
        .d    (d),
        .en   (en),
        .dir  (dir),
        .out  (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report a mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict via arithmetic model, then compare after the edge
    task automatic step(input logic r, input logic e, input logic dr, input logic dd);
        exp_t ex;
        exp_t got_ex;
        @(negedge clk);
        rstn = r;
        en   = e;
        dir  = dr;
        d    = dd;
        if (!r) begin
            m16 = 16'h0000;
            m4  = 4'h0;
        end else if (e) begin
            if (dr) begin
                m16 = 16'(m16 / 2) | (dd ? 16'h8000 : 16'h0000);
                m4  = 4'(m4 / 2)   | (dd ? 4'h8 : 4'h0);
            end else begin
                m16 = 16'((32'(m16) * 2 + 32'(dd)) % 65536);
                m4  = 4'((32'(m4) * 2 + 32'(dd)) % 16);
            end
        end
        ex.e16 = m16;
        ex.e4  = m4;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got_ex = sb_q.pop_front();
            check("sb16", 32'(out16), 32'(got_ex.e16));
            check("sb4",  32'(out4),  32'(got_ex.e4));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m16    = 16'h0000;
        m4     = 4'h0;
        rstn   = 1'b0;
        en     = 1'b0;
        dir    = 1'b0;
        d      = 1'b0;

        // Initial reset
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("init_rst", 32'(out16), 32'h0000);

        // 1. Reset overrides en on a preloaded register
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("preload", 32'(out16), 32'h0007);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("rst_over_en", 32'(out16), 32'h0000);
        check("rst_over_en4", 32'(out4), 32'h0);

        // 2. Left fill, both widths
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("lfill1", 32'(out16), 32'h0001);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("lfill2", 32'(out16), 32'h0003);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("lfill3", 32'(out16), 32'h0007);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("lfill4_w4", 32'(out4), 32'hE);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("lfill5_w4", 32'(out4), 32'hD);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("lfill_pat", 32'(out16), 32'h0075);

        // 3. Right fill
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rfill1", 32'(out16), 32'h8000);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rfill2", 32'(out16), 32'hC000);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("rfill4", 32'(out16), 32'h3000);

        // 4. Hold while en is low, d and dir toggling
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'(i % 2), 1'((i + 1) % 2));
            check("hold", 32'(out16), 32'h0007);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_resume", 32'(out16), 32'h000E);

        // 5. Direction switch with no bubble
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("dsw1", 32'(out16), 32'h0003);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("dsw2", 32'(out16), 32'h8001);

        // 6. Overflow, then mid-operation reset and release
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (i >= 15) check("ovf", 32'(out16), 32'hFFFF);
        end
        check("ovf_w4", 32'(out4), 32'hF);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("mid_rst", 32'(out16), 32'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_release", 32'(out16), 32'h0001);

        // Random mix against the model
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg.md
Name: shift_reg

Overview:
Parameterised serial-in, parallel-out bidirectional shift register. Each enabled clock edge shifts one serial bit `d` into the register from the LSB end (left shift) or the MSB end (right shift), as selected by `dir`. The full register is always visible on `out`. Used wherever a serial bit stream must be assembled into a parallel word in either bit order.

Parameters:
MSB, 16, register width in bits; legal range MSB >= 2; `out` is MSB bits wide, indices [MSB-1:0].

Ports:
clk  input  1  clock; all state changes on rising edge.
rstn  input  1  synchronous reset, active-low; sampled on rising edge of clk.
d  input  1  serial data bit shifted in.
en  input  1  shift enable; 1 = shift this cycle, 0 = hold.
dir  input  1  shift direction; 0 = left (toward MSB), 1 = right (toward LSB).
out  output  MSB  current register contents, driven directly from flops.

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-low (ports clk and rstn).
- Single register reg_q[MSB-1:0] drives out directly; no combinational path from inputs to out.
- Evaluation order at each rising edge of clk, highest priority first:
  - rstn == 0: reg_q <= all zeros, regardless of en, dir and d.
  - rstn == 1, en == 0: reg_q holds its value.
  - rstn == 1, en == 1, dir == 0 (left shift): reg_q <= {reg_q[MSB-2:0], d}. d enters bit 0 and bit MSB-1 is discarded.
  - rstn == 1, en == 1, dir == 1 (right shift): reg_q <= {d, reg_q[MSB-1:1]}. d enters bit MSB-1 and bit 0 is discarded.
- Reset value of out: all zeros. Before the first reset edge, out is undefined; no power-on value is required.
- Latency: d, en and dir sampled at edge N are reflected on out immediately after edge N (one-cycle register latency).
- Direction change: dir may change on any cycle. The new direction applies to the next enabled edge, with no flush and no bubble. Existing bits move the opposite way from that edge on.
- en and dir have no effect during reset.
- Reset mid-operation: a low rstn at any edge clears the whole register. Shifting resumes at the first edge with rstn == 1 and en == 1.
- X on d while en == 1 propagates into the register. X on d while en == 0 has no effect.
- No wrap-around: the bit shifted out is lost.
- No saturation or count logic; the register holds state indefinitely while en == 0.

Test Plan:
1. Reset: rstn=0 for 1 edge with en=1, d=1, register preloaded non-zero -> out=16'h0000 after that edge. Reset must override en.
2. Left fill: after reset, en=1, dir=0, d=1 for 3 edges -> out=16'h0001, 16'h0003, 16'h0007. Then d alternating 0,1,0,1 for 4 edges -> out=16'h0075.
3. Right fill: after reset, en=1, dir=1, d=1 for 2 edges -> out=16'h8000, then 16'hC000. Then d=0 for 2 edges -> out=16'h3000.
4. Hold: out=16'h0007, set en=0, toggle d and dir for 5 edges -> out stays 16'h0007. Restore en=1, dir=0, d=0 -> out=16'h000E.
5. Direction switch: from out=16'h0007, set dir=1, d=0 -> out=16'h0003. Then d=1 -> out=16'h8001.
6. Overflow and mid-operation reset: left shift d=1 for 20 edges -> out=16'hFFFF after 16 edges and stays 16'hFFFF. Then rstn=0 for one edge with en=1 -> out=16'h0000. Release rstn with d=1, dir=0 -> out=16'h0001.
Also run case 2 with MSB=4: 3 ones then d pattern 0,1 -> 4'hE, then 4'hD.
